// File: rtl/homin_izh_neuron.sv
// Izhikevich regular-spiking neuron: one forward-Euler step (dt = 2^-DT_SHIFT ms) per update.
// The v*v term comes from a linear-mode CORDIC multiplier; v and u are held in Q15.16.
module homin_izh_neuron #(
   parameter int                 CORDIC_ITERS = 8,
   parameter logic signed [15:0] V_TH         = 16'sd1536,
   parameter logic signed [15:0] V_RESET      = -16'sd3328,
   parameter logic signed [15:0] U_INC        = 16'sd410,
   parameter int                 DT_SHIFT     = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic signed [15:0] input_current,
   input  logic signed [7:0]  q4_4_in,
   output logic signed [15:0] v,
   output logic               spike,
   output logic               ready
);

   localparam int W  = 32;
   localparam int WA = 35;  // five Q15.16 terms summed without wrap
   localparam int WS = 36;
   localparam int IW = $clog2(CORDIC_ITERS + 1);

   typedef enum logic [1:0] {S_IDLE, S_CORDIC, S_ACCUM, S_UPDATE} state_t;

   function automatic logic signed [W-1:0] widen_q69(input logic signed [15:0] a);
      widen_q69 = {{(W-23){a[15]}}, a, 7'b0};
   endfunction

   localparam logic signed [WS-1:0] MAX32 = {5'b0, {31{1'b1}}};
   localparam logic signed [WS-1:0] MIN32 = {{5{1'b1}}, 31'b0};

   function automatic logic signed [W-1:0] sat32(input logic signed [WS-1:0] a);
      if (a > MAX32)      sat32 = {1'b0, {31{1'b1}}};
      else if (a < MIN32) sat32 = {1'b1, 31'b0};
      else                sat32 = a[W-1:0];
   endfunction

   localparam logic signed [W-1:0]  V_TH_W    = widen_q69(V_TH);
   localparam logic signed [W-1:0]  V_RESET_W = widen_q69(V_RESET);
   localparam logic signed [W-1:0]  U_INC_W   = widen_q69(U_INC);
   localparam logic signed [W-1:0]  U_RESET_W = widen_q69(-16'sd666);
   localparam logic signed [WA-1:0] C14       = 35'sd917504;

   state_t               state_q, state_d;
   logic [IW-1:0]        iter_q, iter_d;
   logic signed [W-1:0]  v_q, v_d, u_q, u_d, x_q, x_d, y_q, y_d;
   logic signed [8:0]    z_q, z_d;
   logic signed [15:0]   cur_q, cur_d;
   logic signed [WA-1:0] dv_q, dv_d, du_q, du_d;
   logic                 spike_q, spike_d, ready_q, ready_d;

   // Port view of v: Q15.16 -> Q6.9 with saturation.
   logic signed [W-8:0]  v_shr;
   logic signed [15:0]   v_port;
   assign v_shr  = v_q[W-1:7];
   assign v_port = (v_shr > 25'sd32767)  ? 16'sh7FFF :
                   (v_shr < -25'sd32768) ? 16'sh8000 : v_shr[15:0];

   // CORDIC step i uses weight 2^(3-i); z is Q4.4 with one guard bit.
   logic signed [W-1:0] term;
   logic signed [8:0]   z_step;
   assign term   = (x_q <<< 3) >>> iter_q;
   assign z_step = $signed(9'd128 >> iter_q);

   logic signed [WA-1:0] ye, ve, ue, cur_w, y_04, v5, bv, bv_u, dv_calc, du_calc;
   assign ye      = {{(WA-W){y_q[W-1]}}, y_q};
   assign ve      = {{(WA-W){v_q[W-1]}}, v_q};
   assign ue      = {{(WA-W){u_q[W-1]}}, u_q};
   assign cur_w   = {{(WA-23){cur_q[15]}}, cur_q, 7'b0};
   assign y_04    = (ye >>> 2) + (ye >>> 3) + (ye >>> 6) + (ye >>> 7);
   assign v5      = (ve <<< 2) + ve;
   assign dv_calc = y_04 + v5 + C14 - ue + cur_w;
   assign bv      = (ve >>> 3) + (ve >>> 4) + (ve >>> 7) + (ve >>> 8);
   assign bv_u    = bv - ue;
   assign du_calc = (bv_u >>> 6) + (bv_u >>> 8) + (bv_u >>> 11);

   logic signed [WA-1:0] dv_dt, du_dt;
   logic signed [WS-1:0] v_sum, u_sum, u_spk_sum;
   logic signed [W-1:0]  v_n, u_n, u_spk;
   logic                 fire;
   assign dv_dt     = dv_q >>> DT_SHIFT;
   assign du_dt     = du_q >>> DT_SHIFT;
   assign v_sum     = {{(WS-W){v_q[W-1]}}, v_q} + {{(WS-WA){dv_dt[WA-1]}}, dv_dt};
   assign u_sum     = {{(WS-W){u_q[W-1]}}, u_q} + {{(WS-WA){du_dt[WA-1]}}, du_dt};
   assign v_n       = sat32(v_sum);
   assign u_n       = sat32(u_sum);
   assign u_spk_sum = {{(WS-W){u_n[W-1]}}, u_n} + {{(WS-W){U_INC_W[W-1]}}, U_INC_W};
   assign u_spk     = sat32(u_spk_sum);
   assign fire      = (v_n >= V_TH_W);

   always_comb begin
      // NOTE: every _d gets a hold default first so no path through the case infers a latch.
      state_d = state_q;
      iter_d  = iter_q;
      v_d     = v_q;
      u_d     = u_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      cur_d   = cur_q;
      dv_d    = dv_q;
      du_d    = du_q;
      spike_d = spike_q;
      ready_d = ready_q;
      case (state_q)
         S_IDLE: begin
            x_d     = widen_q69(v_port);
            y_d     = '0;
            z_d     = {q4_4_in[7], q4_4_in};
            cur_d   = input_current;
            iter_d  = '0;
            ready_d = 1'b0;
            state_d = S_CORDIC;
         end
         S_CORDIC: begin
            if (!z_q[8]) begin
               y_d = y_q + term;
               z_d = z_q - z_step;
            end else begin
               y_d = y_q - term;
               z_d = z_q + z_step;
            end
            iter_d = iter_q + IW'(1);
            if (iter_q == IW'(CORDIC_ITERS - 1)) state_d = S_ACCUM;
         end
         S_ACCUM: begin
            dv_d    = dv_calc;
            du_d    = du_calc;
            state_d = S_UPDATE;
         end
         S_UPDATE: begin
            if (fire) begin
               v_d     = V_RESET_W;
               u_d     = u_spk;
               spike_d = 1'b1;
            end else begin
               v_d     = v_n;
               u_d     = u_n;
               spike_d = 1'b0;
            end
            ready_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         iter_q  <= '0;
         v_q     <= V_RESET_W;
         u_q     <= U_RESET_W;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         cur_q   <= '0;
         dv_q    <= '0;
         du_q    <= '0;
         spike_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         v_q     <= v_d;
         u_q     <= u_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         cur_q   <= cur_d;
         dv_q    <= dv_d;
         du_q    <= du_d;
         spike_q <= spike_d;
         ready_q <= ready_d;
      end
   end

   assign v     = v_port;
   assign spike = spike_q;
   assign ready = ready_q;

endmodule

// File: tb/tb_homin_izh_neuron.sv
// Scoreboard bench for homin_izh_neuron: the driver pushes expected (v, spike) per step,
// a monitor pops and compares on every rising edge of ready.
`timescale 1ns/1ps
module tb_homin_izh_neuron;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [15:0] input_current = '0;
   logic signed [7:0]  q4_4_in = '0;
   logic signed [15:0] v;
   logic               spike;
   logic               ready;

   always #5 clk = ~clk;

   homin_izh_neuron dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .input_current (input_current),
      .q4_4_in       (q4_4_in),
      .v             (v),
      .spike         (spike),
      .ready         (ready)
   );

   typedef struct packed {
      logic signed [15:0] v;
      logic               spike;
   } exp_t;

   localparam longint MAX32 = 64'sd2147483647;
   localparam longint MIN32 = -64'sd2147483648;

   exp_t   exp_q[$];
   int     n_checks = 0;
   int     n_errors = 0;
   longint m_v, m_u;
   bit     done = 1'b0;
   bit     hand_valid = 1'b0;
   exp_t   hand_exp;

   task automatic check(input string name, input longint actual, input longint expected);
      n_checks++;
      if (actual != expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic range_check(input string name, input longint actual, input longint lo, input longint hi);
      n_checks++;
      if (actual < lo || actual > hi) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected within [%0d, %0d] (t=%0t)", name, actual, lo, hi, $time);
      end
   endtask

   function automatic longint sat32(input longint a);
      if (a > MAX32) return MAX32;
      if (a < MIN32) return MIN32;
      return a;
   endfunction

   function automatic logic signed [15:0] port_of(input longint vi);
      longint s;
      s = vi >>> 7;
      if (s > 32767)  return 16'sh7FFF;
      if (s < -32768) return 16'sh8000;
      return 16'(s);
   endfunction

   function automatic logic signed [7:0] q_of(input logic signed [15:0] pv);
      logic signed [15:0] t;
      t = pv >>> 5;
      return t[7:0];
   endfunction

   task automatic model_reset();
      m_v = -3328 * 128;
      m_u = -666 * 128;
   endtask

   // Reference Euler step in Q15.16 using 64-bit integers.
   task automatic model_step(input logic signed [15:0] cur, input logic signed [7:0] q, output exp_t e);
      longint x, y, t, dv, du, bv, d, vn, un;
      int     z;
      x = longint'(port_of(m_v)) * 128;
      y = 0;
      z = int'(q);
      for (int i = 0; i < 8; i++) begin
         t = (x * 8) >>> i;
         if (z >= 0) begin
            y += t;
            z -= (128 >> i);
         end else begin
            y -= t;
            z += (128 >> i);
         end
      end
      dv = (y >>> 2) + (y >>> 3) + (y >>> 6) + (y >>> 7) + 5 * m_v + 14 * 65536 - m_u + longint'(cur) * 128;
      bv = (m_v >>> 3) + (m_v >>> 4) + (m_v >>> 7) + (m_v >>> 8);
      d  = bv - m_u;
      du = (d >>> 6) + (d >>> 8) + (d >>> 11);
      vn = sat32(m_v + (dv >>> 5));
      un = sat32(m_u + (du >>> 5));
      if (vn >= 1536 * 128) begin
         m_v     = -3328 * 128;
         m_u     = sat32(un + 410 * 128);
         e.spike = 1'b1;
      end else begin
         m_v     = vn;
         m_u     = un;
         e.spike = 1'b0;
      end
      e.v = port_of(m_v);
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge where ready is back.
   task automatic do_step(input logic signed [15:0] cur, input logic signed [15:0] alt, input bit use_alt);
      exp_t              e;
      int                lat;
      logic signed [7:0] q;
      q             = q_of(port_of(m_v));
      input_current = cur;
      q4_4_in       = q;
      model_step(cur, q, e);
      if (hand_valid) begin
         exp_q.push_back(hand_exp);
         hand_valid = 1'b0;
      end else begin
         exp_q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      if (use_alt) input_current = alt;
      lat = 0;
      while (!ready && lat < 40) begin
         lat++;
         @(negedge clk);
      end
      check("busy_cycles", lat, 10);
   endtask

   // Monitor: one comparison per completed update.
   initial begin
      exp_t e;
      bit   ready_prev;
      ready_prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n || done) begin
            ready_prev = 1'b1;
         end else begin
            if (ready && !ready_prev) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_update", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("update_v", v, e.v);
                  check("update_spike", spike, e.spike);
               end
            end
            ready_prev = ready;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int                 spikes;
      logic signed [15:0] prev_v;

      model_reset();
      repeat (10) @(negedge clk);
      check("reset_v", v, -3328);
      check("reset_spike", spike, 0);
      check("reset_ready", ready, 1);

      // First update from reset with I = 0, q = -104 worked by hand: v -> -3337, no spike.
      hand_exp.v     = -16'sd3337;
      hand_exp.spike = 1'b0;
      hand_valid     = 1'b1;
      #2 rst_n = 1'b1;

      for (int s = 0; s < 1000; s++) begin
         do_step(16'sd0, 16'sd0, 1'b0);
         check("rest_no_spike", spike, 0);
         range_check("rest_v", v, -4096, -2816);
      end

      spikes = 0;
      for (int s = 0; s < 1500; s++) begin
         do_step(16'sd7680, 16'sd0, 1'b0);
         if (spike) begin
            spikes++;
            check("tonic_spike_v", v, -3328);
         end
         range_check("tonic_v", v, -32768, 1535);
      end
      range_check("tonic_spike_count", spikes, 5, 1500);

      // Input changes after the start edge must not affect the result.
      do_step(16'sd2000, -16'sd2000, 1'b1);

      // Abort an update mid-CORDIC with reset.
      input_current = 16'sd7680;
      q4_4_in       = q_of(port_of(m_v));
      @(posedge clk);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_v", v, -3328);
      check("midrst_spike", spike, 0);
      check("midrst_ready", ready, 1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      check("midrst_release_v", v, -3328);
      check("midrst_release_spike", spike, 0);
      model_reset();

      spikes = 0;
      prev_v = v;
      for (int s = 0; s < 300; s++) begin
         do_step(16'sd32767, 16'sd0, 1'b0);
         if (spike) begin
            spikes++;
            check("sat_spike_v", v, -3328);
         end else begin
            check("sat_no_wrap", (prev_v > 0 && v < 0) ? 1 : 0, 0);
         end
         prev_v = v;
      end
      range_check("sat_spike_count", spikes, 10, 300);

      @(negedge clk);
      done = 1'b1;
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
